// File: rtl/accum_sequencer.sv
// accum_sequencer: frame controller for spectrum accumulation and upload.
// Arms on start, accumulates pulse_num laser pulses into the buffer, then
// waits FLUSH_CYC cycles and drains the buffer to the host in BURST-word bursts.
// Underrun watchdogs in both upload states end the frame early and raise
// a sticky error flag.
module accum_sequencer #(
  parameter int PULSE_W     = 16,
  parameter int WORDS_TOTAL = 8192,
  parameter int BURST       = 2048,
  parameter int FLUSH_CYC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PULSE_W-1:0] pulse_num,
  input  logic               laser_trig,
  input  logic               valid_in,
  input  logic               upload_en,
  input  logic               valid_out,
  input  logic               host_rdy,
  output logic               buffer_en,
  output logic               is_first_pls,
  output logic               valid_gated,
  output logic               upload_trig,
  output logic               fifo_srst,
  output logic               busy,
  output logic               done,
  output logic               err_underrun,
  output logic [PULSE_W-1:0] pls_cnt
);

  localparam int WC_W = $clog2(WORDS_TOTAL) + 1;
  localparam int BC_W = $clog2(BURST) + 1;
  localparam int FC_W = $clog2(FLUSH_CYC) + 1;

  localparam logic [WC_W-1:0] WORDS_L    = WC_W'(WORDS_TOTAL);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  // UP_WAIT tolerates 16 idle cycles; the 17th raises the error.
  localparam logic [6:0]      WAIT_LIM   = 7'd16;
  // UP_BURST errors on the 64th consecutive cycle without a word.
  localparam logic [6:0]      IDLE_LAST  = 7'd63;

  typedef enum logic [2:0] {
    IDLE, ARM, ACCUM, FLUSH, UP_WAIT, UP_BURST, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PULSE_W-1:0] target_q, target_d;
  logic [PULSE_W-1:0] pls_cnt_q, pls_cnt_d;
  logic               first_q, first_d;
  logic               err_q, err_d;
  logic               vin_q;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [6:0]         tmo_q, tmo_d;

  logic               vin_fall;
  logic [PULSE_W-1:0] pls_inc;
  logic [WC_W-1:0]    word_inc;

  // Pulse boundary: falling edge of valid_in against its registered copy.
  assign vin_fall = vin_q & ~valid_in;
  // Saturating increments so neither counter can wrap.
  assign pls_inc  = (pls_cnt_q == '1) ? pls_cnt_q : pls_cnt_q + 1'b1;
  assign word_inc = (word_cnt_q == WORDS_L) ? word_cnt_q : word_cnt_q + 1'b1;

  assign buffer_en    = (state_q == IDLE) || (state_q == ARM) ||
                        (state_q == ACCUM) || (state_q == FLUSH);
  assign busy         = (state_q != IDLE);
  assign valid_gated  = (state_q == ACCUM) & valid_in;
  assign is_first_pls = first_q;
  assign err_underrun = err_q;
  assign pls_cnt      = pls_cnt_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame datapath registers: counters, latched target, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q    <= '0;
      pls_cnt_q   <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      vin_q       <= 1'b0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      flush_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      target_q    <= target_d;
      pls_cnt_q   <= pls_cnt_d;
      first_q     <= first_d;
      err_q       <= err_d;
      vin_q       <= valid_in;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state and strobe outputs; abort outranks every other transition.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    pls_cnt_d   = pls_cnt_q;
    first_d     = first_q;
    err_d       = err_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;
    flush_cnt_d = flush_cnt_q;
    tmo_d       = tmo_q;
    upload_trig = 1'b0;
    fifo_srst   = 1'b0;
    done        = 1'b0;

    if (abort && (state_q != IDLE)) begin
      fifo_srst = 1'b1;
      first_d   = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            // A zero pulse count would never terminate; run one pulse instead.
            target_d    = (pulse_num == '0) ? PULSE_W'(1) : pulse_num;
            pls_cnt_d   = '0;
            word_cnt_d  = '0;
            burst_cnt_d = '0;
            flush_cnt_d = '0;
            tmo_d       = '0;
            err_d       = 1'b0;
            first_d     = 1'b0;
            state_d     = ARM;
          end
        end
        ARM: begin
          if (laser_trig) begin
            first_d = 1'b1;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          // laser_trig is ignored here; only valid_in falls count pulses.
          if (vin_fall) begin
            pls_cnt_d = pls_inc;
            first_d   = 1'b0;
            if (pls_inc == target_q) begin
              flush_cnt_d = '0;
              state_d     = FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            tmo_d   = '0;
            state_d = UP_WAIT;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        UP_WAIT: begin
          if (upload_en && host_rdy) begin
            upload_trig = 1'b1;
            burst_cnt_d = '0;
            tmo_d       = '0;
            state_d     = UP_BURST;
          end else if (!upload_en && (word_cnt_q < WORDS_L)) begin
            if (tmo_q == WAIT_LIM) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end else begin
            // Data is available but the host is stalling: not an underrun.
            tmo_d = '0;
          end
        end
        UP_BURST: begin
          if (valid_out) begin
            word_cnt_d = word_inc;
            tmo_d      = '0;
            if (burst_cnt_q == BURST_LAST) begin
              burst_cnt_d = '0;
              state_d     = (word_inc == WORDS_L) ? DONE : UP_WAIT;
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
            end
          end else if (tmo_q == IDLE_LAST) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        DONE: begin
          done      = 1'b1;
          fifo_srst = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: scenario tasks with randomized pulse shapes and a
// randomized buffer responder; expectations come from frame-level arithmetic.
module tb_accum_sequencer;
  localparam int PW = 16;
  localparam int WT = 8192;
  localparam int BU = 2048;
  localparam int FC = 4;
  localparam int EXP_BURSTS = (WT + BU - 1) / BU;

  logic clk = 1'b0;
  logic rst, start, abort, laser_trig, valid_in, upload_en, valid_out, host_rdy;
  logic [PW-1:0] pulse_num;
  logic buffer_en, is_first_pls, valid_gated, upload_trig, fifo_srst, busy, done, err_underrun;
  logic [PW-1:0] pls_cnt;

  accum_sequencer #(.PULSE_W(PW), .WORDS_TOTAL(WT), .BURST(BU), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pulse_num(pulse_num),
    .laser_trig(laser_trig), .valid_in(valid_in), .upload_en(upload_en),
    .valid_out(valid_out), .host_rdy(host_rdy), .buffer_en(buffer_en),
    .is_first_pls(is_first_pls), .valid_gated(valid_gated), .upload_trig(upload_trig),
    .fifo_srst(fifo_srst), .busy(busy), .done(done), .err_underrun(err_underrun),
    .pls_cnt(pls_cnt));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level event monitor, sampled mid-cycle.
  int n_done = 0, n_srst = 0, n_trig = 0, n_words = 0, n_flush = 0, n_trig_bad = 0;
  int done_cyc = 0, up_cyc = 0, exp_target = 1;
  logic prev_ben = 1'b1;
  always @(negedge clk) begin
    if (done === 1'b1) begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (fifo_srst === 1'b1) n_srst <= n_srst + 1;
    if (upload_trig === 1'b1) begin
      n_trig <= n_trig + 1;
      if (!(host_rdy && upload_en)) n_trig_bad <= n_trig_bad + 1;
    end
    if (valid_out && busy && !buffer_en) n_words <= n_words + 1;
    if (busy && buffer_en && (int'(pls_cnt) == exp_target)) n_flush <= n_flush + 1;
    if (prev_ben && !buffer_en && busy) up_cyc <= cyc;
    prev_ben <= buffer_en;
  end

  // Buffer model: each upload_trig yields BU words with random gaps,
  // capped at buf_limit words total to emulate a starving buffer.
  int sent_total = 0, buf_limit = 32'h7fffffff, last_word_cyc = 0;
  bit resp_busy = 1'b0;
  initial begin
    int w;
    valid_out = 1'b0;
    forever begin
      @(negedge clk);
      if (upload_trig === 1'b1) begin
        resp_busy = 1'b1;
        w = 0;
        while (w < BU && sent_total < buf_limit) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 3) != 0) begin
            valid_out = 1'b1; w++; sent_total++; last_word_cyc = cyc;
          end else valid_out = 1'b0;
        end
        @(posedge clk); #1;
        valid_out = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic begin_frame(input int n);
    tick(); start = 1'b1; pulse_num = PW'(n);
    tick(); start = 1'b0;
  endtask

  // One laser pulse: trigger, short gap, valid_in high for len cycles.
  // Returns one cycle after the fall, when pls_cnt has just updated.
  task automatic pulse(input int idx, input int len, input bit mid_trig);
    logic exp_first;
    exp_first = (idx == 1);
    laser_trig = 1'b1; tick(); laser_trig = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    valid_in = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == len / 2) begin
        #1;
        if (is_first_pls !== exp_first) begin
          n_err++; $display("FAIL is_first_pulse%0d: got %b expected %b", idx, is_first_pls, exp_first);
        end
        n_vec++;
        if (valid_gated !== 1'b1) begin
          n_err++; $display("FAIL valid_gated_accum: got %b expected 1", valid_gated);
        end
        n_vec++;
        if (mid_trig) laser_trig = 1'b1;
      end
      tick(); laser_trig = 1'b0;
    end
    valid_in = 1'b0;
    tick();
    if (is_first_pls !== 1'b0) begin
      n_err++; $display("FAIL is_first_after%0d: got %b expected 0", idx, is_first_pls);
    end
    n_vec++;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, budget);
    end
    n_vec++;
  endtask

  task automatic wait_upload(input int budget, input string name);
    int k = 0;
    while (buffer_en && k < budget) begin tick(); k++; end
    if (buffer_en !== 1'b0) begin
      n_err++; $display("FAIL %s_upwait_timeout: buffer_en=%b expected 0", name, buffer_en);
    end
    n_vec++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; laser_trig = 0; valid_in = 0;
    upload_en = 1; host_rdy = 1; pulse_num = '0;
    #12;
    if ({buffer_en, is_first_pls, valid_gated, upload_trig, fifo_srst, busy, done, err_underrun} !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 10000000",
        {buffer_en, is_first_pls, valid_gated, upload_trig, fifo_srst, busy, done, err_underrun});
    end
    n_vec++;
    if (pls_cnt !== '0) begin n_err++; $display("FAIL reset_pls_cnt: got %0d expected 0", pls_cnt); end
    n_vec++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_normal();
    int s_done = n_done, s_srst = n_srst, s_trig = n_trig, s_words = n_words, s_flush = n_flush;
    exp_target = 3;
    begin_frame(3);
    if (busy !== 1'b1 || pls_cnt !== '0) begin
      n_err++; $display("FAIL normal_start: busy=%b pls_cnt=%0d expected 1/0", busy, pls_cnt);
    end
    n_vec++;
    for (int k = 1; k <= 3; k++) begin
      pulse(k, 100, k == 2);
      if (int'(pls_cnt) != k) begin n_err++; $display("FAIL normal_pls_cnt: got %0d expected %0d", pls_cnt, k); end
      n_vec++;
      repeat ($urandom_range(2, 6)) tick();
    end
    wait_idle(30000, "normal");
    if (n_done - s_done != 1) begin n_err++; $display("FAIL normal_done: got %0d expected 1", n_done - s_done); end
    n_vec++;
    if (n_srst - s_srst != 1) begin n_err++; $display("FAIL normal_srst: got %0d expected 1", n_srst - s_srst); end
    n_vec++;
    if (n_trig - s_trig != EXP_BURSTS) begin n_err++; $display("FAIL normal_trig: got %0d expected %0d", n_trig - s_trig, EXP_BURSTS); end
    n_vec++;
    if (n_words - s_words != WT) begin n_err++; $display("FAIL normal_words: got %0d expected %0d", n_words - s_words, WT); end
    n_vec++;
    if (n_flush - s_flush != FC) begin n_err++; $display("FAIL normal_flush: got %0d expected %0d", n_flush - s_flush, FC); end
    n_vec++;
    if (err_underrun !== 1'b0) begin n_err++; $display("FAIL normal_err: got %b expected 0", err_underrun); end
    n_vec++;
  endtask

  task automatic test_zero_count();
    int s_done = n_done, s_trig = n_trig, s_flush = n_flush;
    exp_target = 1;
    begin_frame(0);
    pulse(1, $urandom_range(10, 60), 1'b0);
    if (pls_cnt !== PW'(1) || buffer_en !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL zero_flush_entry: pls_cnt=%0d buffer_en=%b busy=%b expected 1/1/1", pls_cnt, buffer_en, busy);
    end
    n_vec++;
    valid_in = 1'b1; #1;
    if (valid_gated !== 1'b0) begin n_err++; $display("FAIL zero_gated_flush: got %b expected 0", valid_gated); end
    n_vec++;
    tick(); valid_in = 1'b0;
    wait_idle(30000, "zero");
    if (n_flush - s_flush != FC) begin n_err++; $display("FAIL zero_flush: got %0d expected %0d", n_flush - s_flush, FC); end
    n_vec++;
    if (n_done - s_done != 1 || n_trig - s_trig != EXP_BURSTS) begin
      n_err++; $display("FAIL zero_frame: done=%0d trig=%0d expected 1/%0d", n_done - s_done, n_trig - s_trig, EXP_BURSTS);
    end
    n_vec++;
  endtask

  task automatic test_backpressure();
    int s_done = n_done, s_trig = n_trig, s_words = n_words;
    int n = $urandom_range(1, 3);
    exp_target = n;
    host_rdy = 1'b0;
    begin_frame(n);
    for (int k = 1; k <= n; k++) begin pulse(k, $urandom_range(5, 80), 1'b0); tick(); end
    wait_upload(100, "bp");
    repeat (500) tick();
    if (n_trig - s_trig != 0 || err_underrun !== 1'b0 || busy !== 1'b1 || buffer_en !== 1'b0) begin
      n_err++; $display("FAIL bp_hold: trig=%0d err=%b busy=%b buffer_en=%b expected 0/0/1/0",
        n_trig - s_trig, err_underrun, busy, buffer_en);
    end
    n_vec++;
    host_rdy = 1'b1; #1;
    if (upload_trig !== 1'b1) begin n_err++; $display("FAIL bp_release_trig: got %b expected 1", upload_trig); end
    n_vec++;
    wait_idle(30000, "bp");
    if (n_done - s_done != 1 || n_trig - s_trig != EXP_BURSTS || n_words - s_words != WT || err_underrun !== 1'b0) begin
      n_err++; $display("FAIL bp_frame: done=%0d trig=%0d words=%0d err=%b expected 1/%0d/%0d/0",
        n_done - s_done, n_trig - s_trig, n_words - s_words, err_underrun, EXP_BURSTS, WT);
    end
    n_vec++;
  endtask

  task automatic test_upload_starve();
    int s_done = n_done, s_trig = n_trig;
    exp_target = 1;
    upload_en = 1'b0;
    begin_frame(1);
    pulse(1, $urandom_range(5, 40), 1'b0);
    wait_upload(50, "starve");
    wait_idle(200, "starve");
    if (err_underrun !== 1'b1 || n_done - s_done != 1 || n_trig - s_trig != 0) begin
      n_err++; $display("FAIL starve_err: err=%b done=%0d trig=%0d expected 1/1/0", err_underrun, n_done - s_done, n_trig - s_trig);
    end
    n_vec++;
    if (done_cyc - up_cyc != 17) begin n_err++; $display("FAIL starve_latency: got %0d expected 17", done_cyc - up_cyc); end
    n_vec++;
    upload_en = 1'b1;
  endtask

  task automatic test_underrun();
    int s_done = n_done, s_srst = n_srst, s_trig = n_trig, s_words = n_words;
    exp_target = 1;
    buf_limit = sent_total + 1000;
    begin_frame(1);
    if (err_underrun !== 1'b0) begin n_err++; $display("FAIL underrun_err_cleared: got %b expected 0", err_underrun); end
    n_vec++;
    pulse(1, $urandom_range(5, 40), 1'b0);
    wait_idle(3000, "underrun");
    if (err_underrun !== 1'b1 || n_done - s_done != 1 || n_srst - s_srst != 1) begin
      n_err++; $display("FAIL underrun_end: err=%b done=%0d srst=%0d expected 1/1/1", err_underrun, n_done - s_done, n_srst - s_srst);
    end
    n_vec++;
    if (n_trig - s_trig != 1 || n_words - s_words != 1000) begin
      n_err++; $display("FAIL underrun_words: trig=%0d words=%0d expected 1/1000", n_trig - s_trig, n_words - s_words);
    end
    n_vec++;
    if (done_cyc - last_word_cyc != 65) begin n_err++; $display("FAIL underrun_latency: got %0d expected 65", done_cyc - last_word_cyc); end
    n_vec++;
    repeat (5) tick();
    if (err_underrun !== 1'b1) begin n_err++; $display("FAIL underrun_sticky: got %b expected 1", err_underrun); end
    n_vec++;
    buf_limit = 32'h7fffffff;
  endtask

  task automatic test_abort();
    int s_done = n_done, s_srst = n_srst, s_trig = n_trig;
    int n = $urandom_range(3, 6);
    exp_target = n;
    begin_frame(n);
    if (err_underrun !== 1'b0) begin n_err++; $display("FAIL abort_err_cleared: got %b expected 0", err_underrun); end
    n_vec++;
    for (int k = 1; k <= 2; k++) begin pulse(k, $urandom_range(5, 50), 1'b0); tick(); end
    if (pls_cnt !== PW'(2)) begin n_err++; $display("FAIL abort_pls_cnt: got %0d expected 2", pls_cnt); end
    n_vec++;
    abort = 1'b1; #1;
    if (fifo_srst !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_strobe: srst=%b done=%b expected 1/0", fifo_srst, done);
    end
    n_vec++;
    tick(); abort = 1'b0;
    if (busy !== 1'b0 || buffer_en !== 1'b1) begin
      n_err++; $display("FAIL abort_idle: busy=%b buffer_en=%b expected 0/1", busy, buffer_en);
    end
    n_vec++;
    // start and abort together in IDLE: nothing happens
    start = 1'b1; abort = 1'b1; pulse_num = PW'(2); #1;
    if (fifo_srst !== 1'b0) begin n_err++; $display("FAIL idle_abort_srst: got %b expected 0", fifo_srst); end
    n_vec++;
    tick(); start = 1'b0; abort = 1'b0;
    if (busy !== 1'b0 || n_srst - s_srst != 1 || n_done - s_done != 0) begin
      n_err++; $display("FAIL start_abort_same: busy=%b srst=%0d done=%0d expected 0/1/0", busy, n_srst - s_srst, n_done - s_done);
    end
    n_vec++;
    exp_target = 2;
    begin_frame(2);
    if (pls_cnt !== '0 || busy !== 1'b1) begin
      n_err++; $display("FAIL abort_restart: pls_cnt=%0d busy=%b expected 0/1", pls_cnt, busy);
    end
    n_vec++;
    for (int k = 1; k <= 2; k++) begin pulse(k, $urandom_range(5, 50), 1'b0); tick(); end
    wait_idle(30000, "abort_clean");
    if (n_done - s_done != 1 || n_trig - s_trig != EXP_BURSTS || err_underrun !== 1'b0) begin
      n_err++; $display("FAIL abort_clean_frame: done=%0d trig=%0d err=%b expected 1/%0d/0",
        n_done - s_done, n_trig - s_trig, err_underrun, EXP_BURSTS);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    int s_done = n_done, s_words = n_words, k = 0;
    exp_target = 1;
    buf_limit = sent_total + 500;
    begin_frame(1);
    pulse(1, $urandom_range(5, 40), 1'b0);
    while ((n_words - s_words) < 300 && k < 3000) begin tick(); k++; end
    if (n_words - s_words < 300) begin n_err++; $display("FAIL rstmid_reach_burst: words=%0d expected >=300", n_words - s_words); end
    n_vec++;
    rst = 1'b1; #1;
    if ({buffer_en, is_first_pls, valid_gated, upload_trig, fifo_srst, busy, done, err_underrun} !== 8'b1000_0000
        || pls_cnt !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got %b pls_cnt=%0d expected 10000000/0",
        {buffer_en, is_first_pls, valid_gated, upload_trig, fifo_srst, busy, done, err_underrun}, pls_cnt);
    end
    n_vec++;
    tick(); rst = 1'b0;
    k = 0;
    while (resp_busy && k < 3000) begin tick(); k++; end
    if (n_done - s_done != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d expected 0", n_done - s_done); end
    n_vec++;
    buf_limit = 32'h7fffffff;
    begin_frame(1);
    if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_restart: busy=%b expected 1", busy); end
    n_vec++;
    abort = 1'b1; tick(); abort = 1'b0;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_cleanup: busy=%b expected 0", busy); end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_count();
    test_backpressure();
    test_upload_starve();
    test_underrun();
    test_abort();
    test_reset_mid();
    if (n_trig_bad != 0) begin n_err++; $display("FAIL trig_without_ready: got %0d expected 0", n_trig_bad); end
    n_vec++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
